fifo: RTL and testbench

FIFO -- requirements
Module: fifo

---
 rtl/fifo.sv | 72 +++++++
 tb/tb_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Single-clock FIFO with combinational head presentation.
// The head word mem[front] is always on read_data; a write into an empty
// FIFO shows up on read_data on the very next cycle. Q_IN_BUFFERS entries
// can be held back so that full asserts early.
//
// Handshake: valid is high whenever rdEn or peek is asserted and the FIFO
// holds at least one entry, so read_data is a real head word for that cycle.
// A read is taken at the rising edge only when rdEn is high and the FIFO is
// not empty. A write is taken when wrtEn is high and either the FIFO is not
// full or a read is taken on the same edge. A write that is not taken is
// dropped. peek never changes state.
module fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int Q_DEPTH_BITS = 3,
  parameter int Q_IN_BUFFERS = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  wrtEn,
  input  logic                  rdEn,
  input  logic                  peek,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  valid,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH      = 1 << Q_DEPTH_BITS;
  localparam int FULL_INT   = DEPTH - Q_IN_BUFFERS;
  localparam logic [Q_DEPTH_BITS:0]   FULL_LEVEL = FULL_INT[Q_DEPTH_BITS:0];
  localparam logic [Q_DEPTH_BITS:0]   CNT_ONE    = 1;
  localparam logic [Q_DEPTH_BITS-1:0] PTR_ONE    = 1;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [Q_DEPTH_BITS-1:0] front;
  logic [Q_DEPTH_BITS-1:0] rear;
  logic [Q_DEPTH_BITS:0]   count;

  logic rd_take;
  logic wr_take;

  // Status flags, head presentation and accept decisions, all from current state.
  always_comb begin
    empty     = (count == '0);
    full      = (count >= FULL_LEVEL);
    read_data = mem[front];
    valid     = (rdEn | peek) & ~empty;
    rd_take   = rdEn & ~empty;
    wr_take   = wrtEn & (~full | rd_take);
  end

  // Pointer and occupancy update; cleared asynchronously, storage is not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      front <= '0;
      rear  <= '0;
      count <= '0;
    end else begin
      if (rd_take) front <= front + PTR_ONE;
      if (wr_take) rear  <= rear + PTR_ONE;
      if (wr_take && !rd_take)      count <= count + CNT_ONE;
      else if (rd_take && !wr_take) count <= count - CNT_ONE;
    end
  end

  // Storage write; contents survive reset and are never cleared on read.
  always_ff @(posedge clk) begin
    if (wr_take) mem[rear] <= write_data;
  end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo with default parameters (32-bit words, 8 entries).
module tb_fifo;

  logic        clk;
  logic        reset;
  logic [31:0] write_data;
  logic        wrtEn;
  logic        rdEn;
  logic        peek;
  logic [31:0] read_data;
  logic        valid;
  logic        full;
  logic        empty;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  fifo dut (
    .clk        (clk),
    .reset      (reset),
    .write_data (write_data),
    .wrtEn      (wrtEn),
    .rdEn       (rdEn),
    .peek       (peek),
    .read_data  (read_data),
    .valid      (valid),
    .full       (full),
    .empty      (empty)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrtEn = 1'b0;
    rdEn  = 1'b0;
    peek  = 1'b0;
  endtask

  // Single write cycle.
  task automatic push(input logic [31:0] d);
    write_data = d;
    wrtEn      = 1'b1;
    tick();
    wrtEn      = 1'b0;
    #1;
  endtask

  logic [31:0] fill_vals [8];

  initial begin
    checks = 0;
    errors = 0;
    write_data = '0;
    idle();
    reset = 1'b0;
    fill_vals = '{32'd51, 32'd78, 32'd39, 32'd23, 32'd44, 32'd19, 32'd32, 32'd88};

    // Reset state, with rdEn/peek high to show valid stays low.
    rdEn = 1'b1;
    peek = 1'b1;
    #2;
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full",  32'(full),  32'd0);
    check_val("rst_valid", 32'(valid), 32'd0);
    idle();
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Single write, peek, read.
    push(32'd100);
    check_val("one_valid_idle", 32'(valid), 32'd0);
    peek = 1'b1;
    #1;
    check_val("one_peek_data",  read_data,   32'd100);
    check_val("one_peek_valid", 32'(valid),  32'd1);
    check_val("one_peek_empty", 32'(empty),  32'd0);
    peek = 1'b0;
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    #1;
    check_val("one_rd_empty", 32'(empty), 32'd1);
    rdEn = 1'b1;
    #1;
    check_val("one_rd_valid", 32'(valid), 32'd0);

    // Read while empty is ignored.
    tick();
    rdEn = 1'b0;
    #1;
    check_val("empty_rd_still_empty", 32'(empty), 32'd1);
    check_val("empty_rd_full",        32'(full),  32'd0);

    // Fill to 8 entries; head stays at the first word.
    for (int i = 0; i < 8; i++) begin
      check_val("fill_full_before", 32'(full), 32'd0);
      push(fill_vals[i]);
      check_val("fill_head",  read_data,   32'd51);
      check_val("fill_empty", 32'(empty),  32'd0);
    end
    check_val("fill_full", 32'(full), 32'd1);

    // Writes while full without rdEn are dropped.
    push(32'd28);
    push(32'd72);
    check_val("drop_full", 32'(full), 32'd1);
    check_val("drop_head", read_data, 32'd51);

    // Read from full.
    rdEn = 1'b1;
    #1;
    check_val("rd_full_valid", 32'(valid), 32'd1);
    check_val("rd_full_head",  read_data,  32'd51);
    tick();
    rdEn = 1'b0;
    #1;
    check_val("rd_full_next", read_data,  32'd78);
    check_val("rd_full_flag", 32'(full),  32'd0);

    // Seven entries: peek plus write refills to full without reading.
    peek       = 1'b1;
    wrtEn      = 1'b1;
    write_data = 32'd89;
    #1;
    check_val("pk_wr_valid", 32'(valid), 32'd1);
    check_val("pk_wr_head",  read_data,  32'd78);
    tick();
    idle();
    #1;
    check_val("pk_wr_full", 32'(full), 32'd1);
    check_val("pk_wr_head_after", read_data, 32'd78);

    // Read and write together while full.
    rdEn       = 1'b1;
    wrtEn      = 1'b1;
    write_data = 32'd17;
    tick();
    idle();
    #1;
    check_val("rw_full_head", read_data, 32'd39);
    check_val("rw_full_flag", 32'(full), 32'd1);

    // Read, peek and write together while full.
    rdEn       = 1'b1;
    peek       = 1'b1;
    wrtEn      = 1'b1;
    write_data = 32'd63;
    #1;
    check_val("rpw_valid", 32'(valid), 32'd1);
    tick();
    idle();
    #1;
    check_val("rpw_head", read_data, 32'd23);
    check_val("rpw_full", 32'(full), 32'd1);

    // Drain and compare against the expected order.
    exp_q = '{32'd23, 32'd44, 32'd19, 32'd32, 32'd88, 32'd89, 32'd17, 32'd63};
    while (exp_q.size() > 0) begin
      rdEn = 1'b1;
      #1;
      check_val("drain_valid", 32'(valid), 32'd1);
      check_val("drain_data",  read_data,  exp_q.pop_front());
      tick();
      rdEn = 1'b0;
      #1;
    end
    check_val("drain_empty", 32'(empty), 32'd1);
    check_val("drain_full",  32'(full),  32'd0);

    // rdEn plus wrtEn while empty performs the write only.
    rdEn       = 1'b1;
    wrtEn      = 1'b1;
    write_data = 32'd5;
    tick();
    idle();
    #1;
    check_val("erw_empty", 32'(empty), 32'd0);
    check_val("erw_head",  read_data,  32'd5);
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    #1;
    check_val("erw_one_entry", 32'(empty), 32'd1);

    // Asynchronous reset with the FIFO full, between clock edges.
    for (int i = 0; i < 8; i++) push(32'd200 + 32'(i));
    check_val("pre_rst_full", 32'(full), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_val("async_rst_empty", 32'(empty), 32'd1);
    check_val("async_rst_full",  32'(full),  32'd0);
    peek = 1'b1;
    #1;
    check_val("async_rst_valid", 32'(valid), 32'd0);
    peek = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Operation resumes after reset.
    push(32'd9);
    check_val("resume_head",  read_data,  32'd9);
    check_val("resume_empty", 32'(empty), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
